// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the memory-port arbiter slice.
//   - owner_e        : which requester owns a transaction (inst = 0, data = 1)
//   - OWN_DEPTH_DEF  : default number of outstanding accepted transactions
//   - STARVE_MAX_DEF : default number of contested losses inst may suffer
//                      before it is forced to win
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int OWN_DEPTH_DEF  = 4;
    localparam int STARVE_MAX_DEF = 3;

endpackage : mem_arb_pkg

// File: rtl/owner_fifo.sv
// -----------------------------------------------------------------------------
// owner_fifo
//   1-bit wide, DEPTH deep FIFO holding the owner of every accepted memory
//   transaction, so in-order responses can be steered back to the requester.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high
//     push       in   write push_data at the tail (ignored when full)
//     push_data  in   owner bit to store
//     pop        in   drop the head entry (ignored when empty)
//     head       out  owner bit at the head (meaningful only when !empty)
//     full       out  registered: DEPTH entries stored
//     empty      out  registered: no entries stored
// -----------------------------------------------------------------------------
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          slots [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow here as well: a pop on an empty FIFO
    // (stray response) must leave both pointers and the count untouched.
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    // Pointers are exactly AW bits, so they wrap around the slot array for
    // free; the extra count bit is what distinguishes full from empty.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order statements are written.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: the slot storage is deliberately not reset; count gates validity,
    // so stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

    assign head  = slots[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule : owner_fifo

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one sram-like memory port between the instruction-fetch requester
//   (inst_*) and the data requester (data_*). Address phases are arbitrated
//   with data priority plus a starvation guard for inst; a grant is locked
//   until mem_addr_ok. The owner of every accepted transaction is queued so
//   the in-order mem_data_ok responses go back to the right requester.
//
//   Ports:
//     clk, reset                       clock; synchronous active-high reset
//     inst_req/wr/size/addr/wdata/wstrb  inst requester address phase
//     inst_addr_ok, inst_data_ok, inst_rdata  inst handshakes and read data
//     data_req/wr/size/addr/wdata/wstrb  data requester address phase
//     data_addr_ok, data_data_ok, data_rdata  data handshakes and read data
//     mem_req/wr/size/addr/wdata/wstrb   downstream address phase
//     mem_rdata, mem_addr_ok, mem_data_ok   downstream responses
//
//   All request/handshake paths are combinational (zero added latency).
//   mem_req depends only on registered FIFO state, never on mem_data_ok.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OWN_DEPTH  = OWN_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic [3:0]  inst_wstrb,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    // Registered state
    logic          lock_valid;
    owner_e        lock_owner;
    logic [SW-1:0] starve_cnt;

    // Combinational grant path
    owner_e grant_owner;
    logic   granted_req;
    logic   both_req;
    logic   handshake;

    // Owner FIFO interface
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic resp_valid;
    owner_e head_owner;

    assign both_req = inst_req && data_req;

    // Grant selection. A pending (locked) grant always wins; otherwise data
    // has priority unless inst has already lost STARVE_MAX contested rounds.
    // NOTE: grant_owner gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_owner = OWN_DATA;
        if (lock_valid) begin
            grant_owner = lock_owner;
        end else if (both_req) begin
            grant_owner = (starve_cnt == STARVE_TOP) ? OWN_INST : OWN_DATA;
        end else if (inst_req) begin
            grant_owner = OWN_INST;
        end
    end

    assign granted_req = (grant_owner == OWN_INST) ? inst_req : data_req;

    // fifo_full is registered, so a pop in this cycle does not reopen the gate
    // until the next cycle; this keeps mem_data_ok off the mem_req path.
    assign mem_req   = granted_req && !fifo_full;
    assign handshake = mem_req && mem_addr_ok;

    // Payload mux follows the grant even when mem_req is low.
    assign mem_wr    = (grant_owner == OWN_INST) ? inst_wr    : data_wr;
    assign mem_size  = (grant_owner == OWN_INST) ? inst_size  : data_size;
    assign mem_addr  = (grant_owner == OWN_INST) ? inst_addr  : data_addr;
    assign mem_wdata = (grant_owner == OWN_INST) ? inst_wdata : data_wdata;
    assign mem_wstrb = (grant_owner == OWN_INST) ? inst_wstrb : data_wstrb;

    assign inst_addr_ok = handshake && (grant_owner == OWN_INST);
    assign data_addr_ok = handshake && (grant_owner == OWN_DATA);

    // Lock and starvation tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_owner <= OWN_INST;
            starve_cnt <= '0;
        end else begin
            // Hold the grant while the address phase is presented but not
            // yet accepted; release it as soon as it is taken or withdrawn.
            lock_valid <= mem_req && !mem_addr_ok;
            lock_owner <= grant_owner;

            if (handshake && grant_owner == OWN_INST) begin
                starve_cnt <= '0;
            end else if (handshake && both_req && grant_owner == OWN_DATA &&
                         starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    owner_fifo #(
        .DEPTH (OWN_DEPTH)
    ) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (handshake),
        .push_data (grant_owner),
        .pop       (mem_data_ok),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A response with nothing outstanding is a protocol error and is dropped.
    assign resp_valid = mem_data_ok && !fifo_empty;
    assign head_owner = owner_e'(fifo_head);

    assign inst_data_ok = resp_valid && (head_owner == OWN_INST);
    assign data_data_ok = resp_valid && (head_owner == OWN_DATA);

    // Read data is broadcast; each requester samples it only with its data_ok.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A reference model (owner queue,
//   held grant, inst loss streak) predicts every output each cycle; directed
//   scenarios add hand-computed literal expectations, then a randomized run
//   exercises arbitration, locking, back-pressure and response routing.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int OWN_DEPTH  = OWN_DEPTH_DEF;
    localparam int STARVE_MAX = STARVE_MAX_DEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = '0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic [3:0]  inst_wstrb = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [3:0]  data_wstrb = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    owner_e m_q[$];          // owners of accepted, unanswered transactions
    bit     m_held;          // a presented request was not taken last cycle
    owner_e m_held_owner;
    int     m_inst_losses;   // contested rounds inst has lost in a row
    bit     m_inst_acc, m_data_acc;

    mem_port_arbiter #(
        .OWN_DEPTH  (OWN_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_wstrb   (inst_wstrb),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Compare process: at each falling edge, predict outputs from the model
    // and the current inputs, compare, then advance the model to the state
    // the next rising edge will produce.
    // ---------------------------------------------------------------------
    always @(negedge clk) begin : cmp
        owner_e g;
        bit g_req, e_req, hs, e_iaok, e_daok, e_idok, e_ddok;
        if (reset) begin
            m_q.delete();
            m_held        = 1'b0;
            m_held_owner  = OWN_INST;
            m_inst_losses = 0;
            m_inst_acc    = 1'b0;
            m_data_acc    = 1'b0;
        end else begin
            if (m_held)                  g = m_held_owner;
            else if (inst_req && data_req) g = (m_inst_losses == STARVE_MAX) ? OWN_INST : OWN_DATA;
            else if (inst_req)           g = OWN_INST;
            else                         g = OWN_DATA;
            g_req  = (g == OWN_INST) ? inst_req : data_req;
            e_req  = g_req && (m_q.size() < OWN_DEPTH);
            hs     = e_req && mem_addr_ok;
            e_iaok = hs && (g == OWN_INST);
            e_daok = hs && (g == OWN_DATA);
            e_idok = mem_data_ok && (m_q.size() > 0) && (m_q[0] == OWN_INST);
            e_ddok = mem_data_ok && (m_q.size() > 0) && (m_q[0] == OWN_DATA);

            check("mem_req",      mem_req,      e_req);
            check("inst_addr_ok", inst_addr_ok, e_iaok);
            check("data_addr_ok", data_addr_ok, e_daok);
            check("inst_data_ok", inst_data_ok, e_idok);
            check("data_data_ok", data_data_ok, e_ddok);
            check("inst_rdata",   inst_rdata,   mem_rdata);
            check("data_rdata",   data_rdata,   mem_rdata);
            if (e_req) begin
                check("mem_addr",  mem_addr,  (g == OWN_INST) ? inst_addr  : data_addr);
                check("mem_wdata", mem_wdata, (g == OWN_INST) ? inst_wdata : data_wdata);
                check("mem_ctl",   {mem_wr, mem_size, mem_wstrb},
                      (g == OWN_INST) ? {inst_wr, inst_size, inst_wstrb}
                                      : {data_wr, data_size, data_wstrb});
            end

            if (mem_data_ok) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else $display("note: stray mem_data_ok with nothing outstanding (t=%0t)", $time);
            end
            if (hs) m_q.push_back(g);
            if (e_iaok) m_inst_losses = 0;
            else if (e_daok && inst_req && data_req && m_inst_losses < STARVE_MAX) m_inst_losses++;
            m_held       = e_req && !mem_addr_ok;
            m_held_owner = g;
            m_inst_acc   = e_iaok;
            m_data_acc   = e_daok;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: a cycle is step(), drive inputs, settle(), literals.
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    task automatic set_inst(input logic [31:0] addr, input logic wr);
        inst_req = 1'b1; inst_addr = addr; inst_wr = wr;
        inst_size = 2'd2; inst_wdata = ~addr; inst_wstrb = 4'hf;
    endtask

    task automatic set_data(input logic [31:0] addr, input logic wr);
        data_req = 1'b1; data_addr = addr; data_wr = wr;
        data_size = 2'd1; data_wdata = addr ^ 32'h5a5a_0000; data_wstrb = 4'h3;
    endtask

    task automatic drain();
        int n;
        n = 0;
        step(); idle();
        while (m_q.size() != 0 && n < 20) begin
            mem_data_ok = 1'b1; mem_rdata = $urandom;
            step(); idle();
            n++;
        end
        check("drain_bounded", 32'(n < 20), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        // Reset
        idle();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        settle();
        check("rst_mem_req",   mem_req, 0);
        check("rst_addr_oks",  {inst_addr_ok, data_addr_ok}, 0);
        check("rst_data_oks",  {inst_data_ok, data_data_ok}, 0);

        // Single data read at 0x1000, response two cycles later
        step(); idle(); set_data(32'h1000, 1'b0); mem_addr_ok = 1'b1; settle();
        check("rd_addr_ok",  data_addr_ok, 1);
        check("rd_mem_addr", mem_addr, 32'h1000);
        check("rd_inst_aok", inst_addr_ok, 0);
        step(); idle(); settle();
        check("rd_no_resp",  {inst_data_ok, data_data_ok}, 0);
        step(); idle(); mem_data_ok = 1'b1; mem_rdata = 32'hcafe_0001; settle();
        check("rd_data_ok",  data_data_ok, 1);
        check("rd_rdata",    data_rdata, 32'hcafe_0001);
        check("rd_inst_dok", inst_data_ok, 0);

        // Both requesting, addr_ok always 1: grants D,D,D,I repeating
        for (int i = 0; i < 8; i++) begin
            step(); idle();
            set_inst(32'h100 + 32'(i) * 4, 1'b0);
            set_data(32'h800 + 32'(i) * 4, 1'b0);
            mem_addr_ok = 1'b1;
            mem_data_ok = (i > 0);
            mem_rdata = $urandom;
            settle();
            check("starve_inst_grant", inst_addr_ok, 32'((i % 4) == 3));
            check("starve_data_grant", data_addr_ok, 32'((i % 4) != 3));
        end
        drain();

        // Lock: inst holds the port while addr_ok is low, data must wait
        step(); idle(); set_inst(32'h2000, 1'b0); settle();
        check("lock_req", mem_req, 1);
        for (int i = 0; i < 2; i++) begin
            step(); idle(); set_inst(32'h2000, 1'b0); set_data(32'h3000, 1'b1); settle();
            check("lock_addr", mem_addr, 32'h2000);
            check("lock_wr",   mem_wr, 0);
            check("lock_daok", data_addr_ok, 0);
        end
        step(); idle(); set_inst(32'h2000, 1'b0); set_data(32'h3000, 1'b1); mem_addr_ok = 1'b1; settle();
        check("lock_iaok",  inst_addr_ok, 1);
        check("lock_addr2", mem_addr, 32'h2000);
        step(); idle(); set_data(32'h3000, 1'b1); mem_addr_ok = 1'b1; settle();
        check("lock_then_data", data_addr_ok, 1);
        check("lock_data_addr", mem_addr, 32'h3000);
        check("lock_data_wr",   mem_wr, 1);
        drain();

        // Fill the owner FIFO (I, D, D, I), then drain with requests pending
        for (int k = 0; k < 4; k++) begin
            step(); idle();
            if (k == 0 || k == 3) set_inst(32'h4000 + 32'(k) * 4, 1'b0);
            else                  set_data(32'h4800 + 32'(k) * 4, 1'b1);
            mem_addr_ok = 1'b1;
            settle();
            check("fill_accept", inst_addr_ok | data_addr_ok, 1);
        end
        step(); idle(); set_inst(32'h4100, 1'b0); set_data(32'h4900, 1'b0); mem_addr_ok = 1'b1; settle();
        check("full_mem_req", mem_req, 0);
        check("full_aoks",    {inst_addr_ok, data_addr_ok}, 0);
        for (int k = 0; k < 4; k++) begin
            step(); idle(); set_data(32'h5000 + 32'(k) * 4, 1'b0);
            mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = $urandom;
            settle();
            check("full_route_i",  inst_data_ok, 32'(k == 0 || k == 3));
            check("full_route_d",  data_data_ok, 32'(k == 1 || k == 2));
            check("full_reopen",   mem_req, 32'(k != 0));
        end
        drain();

        // Push and pop together at count 2 across pointer wrap
        step(); idle(); set_inst(32'h6000, 1'b0); mem_addr_ok = 1'b1;
        step(); idle(); set_data(32'h6800, 1'b0); mem_addr_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); idle();
            if (i % 2 == 0) set_inst(32'h7000 + 32'(i) * 4, 1'b0);
            else            set_data(32'h7800 + 32'(i) * 4, 1'b1);
            mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = $urandom;
            settle();
            check("wrap_mem_req", mem_req, 1);
            check("wrap_route_i", inst_data_ok, 32'(i % 2 == 0));
            check("wrap_route_d", data_data_ok, 32'(i % 2 == 1));
        end
        drain();

        // Reset with two outstanding and an inst lock pending
        step(); idle(); set_inst(32'h8000, 1'b0); mem_addr_ok = 1'b1;
        step(); idle(); set_data(32'h8800, 1'b0); mem_addr_ok = 1'b1;
        step(); idle(); set_inst(32'h8004, 1'b0);
        step(); idle(); reset = 1'b1;
        step(); reset = 1'b0; idle();
        set_inst(32'h8004, 1'b0); set_data(32'h8808, 1'b0); mem_data_ok = 1'b1;
        settle();
        check("rst_stray_i",   inst_data_ok, 0);
        check("rst_stray_d",   data_data_ok, 0);
        check("rst_unlocked",  mem_addr, 32'h8808);
        check("rst_no_iaok",   inst_addr_ok, 0);
        step(); idle(); set_data(32'h8808, 1'b0); mem_addr_ok = 1'b1; settle();
        check("rst_data_go",   data_addr_ok, 1);
        drain();

        // Randomized traffic following the requester/bridge protocols
        for (int c = 0; c < 1500; c++) begin
            step();
            if (!(inst_req && !m_inst_acc)) begin
                inst_req   = ($urandom_range(0, 2) != 0);
                inst_wr    = 1'($urandom);
                inst_size  = 2'($urandom);
                inst_addr  = $urandom;
                inst_wdata = $urandom;
                inst_wstrb = 4'($urandom);
            end
            if (!(data_req && !m_data_acc)) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
                data_wstrb = 4'($urandom);
            end
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (m_q.size() != 0) && ($urandom_range(0, 2) != 0);
            mem_rdata   = $urandom;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
